// File: rtl/iter_mdu_pkg.sv
// Shared encodings and operand-class helpers for the iterative multiply/divide unit.
package iter_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  localparam int WORD_BITS = 32;

  function automatic logic is_div_op(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic src1_signed(input mdu_op_e op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic src2_signed(input mdu_op_e op);
    return op inside {MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/iter_mdu_if.sv
// Issue/result handshake bundle between the execute stage and iter_mdu.
interface iter_mdu_if #(parameter int XLEN = 64);
  import iter_mdu_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  mdu_op_e         op;
  logic            op_w;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output flush, in_valid, op, op_w, src1, src2, out_ready,
    input  in_ready, out_valid, result, illegal
  );

  modport slave (
    input  flush, in_valid, op, op_w, src1, src2, out_ready,
    output in_ready, out_valid, result, illegal
  );

endinterface

// File: rtl/iter_mdu_div.sv
// Restoring-division datapath: one quotient bit per step on unsigned magnitudes.
// Only instantiated when ALU_MDU_DIV_EN is defined.
module iter_mdu_div #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] quo_init,
  input  logic [XLEN-1:0] rem_init,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic            fits;

  // Dividend bits stream out of the top of quo while quotient bits enter at the bottom.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    fits    = (shifted >= {1'b0, dvs_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo   <= '0;
      rem   <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo   <= quo_init;
      rem   <= rem_init;
      dvs_q <= divisor;
    end else if (step) begin
      rem <= fits ? XLEN'(shifted - {1'b0, dvs_q}) : shifted[XLEN-1:0];
      quo <= {quo[XLEN-2:0], fits};
    end
  end

endmodule

// File: rtl/iter_mdu.sv
// Iterative RV64M multiply/divide unit: FSM, counter, handshake and sign fix-up.
// Define ALU_MDU_DIV_EN to build in the divider; otherwise ops 4-7 report illegal.
module iter_mdu
  import iter_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic       clk,
  input logic       rst_n,
  iter_mdu_if.slave bus
);

  localparam int            CW        = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_FULL = CW'(XLEN - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORD_BITS - 1);

  mdu_state_e        state, state_nxt;
  logic [CW-1:0]     cnt;
  mdu_op_e           op_q;
  logic              word_q;
  logic              neg_q;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] acc;
  logic              out_valid_q;
  logic              illegal_q;
  logic [XLEN-1:0]   result_q;

  logic              word_in;
  logic              s1_neg, s2_neg;
  logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b;
  logic              accept, fast, calc_last, q_sign_kill;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   div_res, raw_res, final_res;
  logic              div_illegal;

  // Operand preparation straight from the issue bus; only latched on accept.
  always_comb begin
    word_in = bus.op_w && (XLEN == 64);
    if (word_in) begin
      a_ext = src1_signed(bus.op) ? XLEN'($signed(bus.src1[31:0])) : XLEN'(bus.src1[31:0]);
      b_ext = src2_signed(bus.op) ? XLEN'($signed(bus.src2[31:0])) : XLEN'(bus.src2[31:0]);
    end else begin
      a_ext = bus.src1;
      b_ext = bus.src2;
    end
    s1_neg    = src1_signed(bus.op) && a_ext[XLEN-1];
    s2_neg    = src2_signed(bus.op) && b_ext[XLEN-1];
    mag_a     = s1_neg ? -a_ext : a_ext;
    mag_b     = s2_neg ? -b_ext : b_ext;
    accept    = bus.in_valid && (state == ST_IDLE) && !bus.flush;
    calc_last = (cnt == (word_q ? LAST_WORD : LAST_FULL));
  end

`ifdef ALU_MDU_DIV_EN
  localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_WORD = ~XLEN'(32'h7FFF_FFFF);

  logic            neg_r, div_zero, div_ovf;
  logic [XLEN-1:0] quo_init, rem_init, div_quo, div_rem, quo_fix, rem_fix;

  // Zero divisor and signed overflow preload the final answer and skip CALC.
  always_comb begin
    div_zero    = (b_ext == '0);
    div_ovf     = src2_signed(bus.op) && (&b_ext) && (a_ext == (word_in ? MIN_WORD : MIN_FULL));
    fast        = is_div_op(bus.op) && (div_zero || div_ovf);
    q_sign_kill = is_div_op(bus.op) && div_zero;
    if (div_zero)     quo_init = '1;
    else if (div_ovf) quo_init = mag_a;
    else if (word_in) quo_init = mag_a << WORD_BITS;
    else              quo_init = mag_a;
    rem_init = div_zero ? mag_a : '0;
  end

  iter_mdu_div #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && is_div_op(bus.op)),
    .step     ((state == ST_CALC) && is_div_op(op_q)),
    .quo_init (quo_init),
    .rem_init (rem_init),
    .divisor  (mag_b),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      neg_r <= 1'b0;
    else if (accept) neg_r <= s1_neg;
  end

  always_comb begin
    quo_fix     = neg_q ? -div_quo : div_quo;
    rem_fix     = neg_r ? -div_rem : div_rem;
    div_res     = (op_q inside {MDU_DIV, MDU_DIVU}) ? quo_fix : rem_fix;
    div_illegal = 1'b0;
  end
`else
  always_comb begin
    fast        = is_div_op(bus.op);
    q_sign_kill = 1'b0;
    div_res     = '0;
    div_illegal = 1'b1;
  end
`endif

  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand & {XLEN{acc[0]}}};
    prod    = word_q ? (acc >> WORD_BITS) : acc;
    prod_s  = neg_q ? -prod : prod;
    if (is_div_op(op_q))      raw_res = div_res;
    else if (op_q == MDU_MUL) raw_res = prod_s[XLEN-1:0];
    else                      raw_res = prod_s[2*XLEN-1:XLEN];
    final_res = word_q ? XLEN'($signed(raw_res[31:0])) : raw_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)                          state_nxt = fast ? ST_DONE : ST_CALC;
      ST_CALC: if (calc_last)                       state_nxt = ST_DONE;
      ST_DONE: if (out_valid_q && bus.out_ready)    state_nxt = ST_IDLE;
      default:                                      state_nxt = ST_IDLE;
    endcase
    if (bus.flush) state_nxt = ST_IDLE;
  end

  // DONE spends its first cycle registering the fixed-up result, then holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      op_q        <= MDU_MUL;
      word_q      <= 1'b0;
      neg_q       <= 1'b0;
      mcand       <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      result_q    <= '0;
    end else if (bus.flush) begin
      cnt         <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= bus.op;
            word_q <= word_in;
            neg_q  <= (s1_neg ^ s2_neg) && !q_sign_kill;
            cnt    <= '0;
            mcand  <= mag_a;
            acc    <= {{XLEN{1'b0}}, mag_b};
          end
        end
        ST_CALC: begin
          cnt <= cnt + 1'b1;
          if (!is_div_op(op_q)) acc <= {mul_sum, acc[XLEN-1:1]};
        end
        ST_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            result_q    <= final_res;
            illegal_q   <= is_div_op(op_q) && div_illegal;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.illegal   = illegal_q;

endmodule
